// File: rtl/sw_stream_pkg.sv
// Shared constants and types for the Smith-Waterman stream endpoint:
// header field layout, result word layout and the parser state encoding.
package sw_stream_pkg;

  // Inbound header word field positions
  localparam int HDR_REF_LSB  = 0;
  localparam int HDR_REF_W    = 32;
  localparam int HDR_ID_LSB   = 32;
  localparam int HDR_ID_W     = 16;
  localparam int HDR_QLEN_LSB = 64;
  localparam int HDR_QLEN_W   = 7;
  localparam int HDR_THR_LSB  = 96;
  localparam int HDR_THR_W    = 32;

  // Outbound result word layout
  localparam int RES_ID_LSB  = 32;
  localparam int RES_LOC_LSB = 0;
  localparam int RES_ID_W    = 16;
  localparam int RES_LOC_W   = 32;
  localparam int RES_ENTRY_W = RES_ID_W + RES_LOC_W;

  // Parser states: expect header, expect query, present job to core
  typedef enum logic [1:0] {
    HDR   = 2'd0,
    QRY   = 2'd1,
    ISSUE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sw_result_fifo.sv
// Circular result buffer between the aligner core and the outbound stream.
// Output data comes straight from the storage array (no fall-through) and
// reads as zero whenever the buffer is empty.
module sw_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             overflow;
  logic             do_push;
  logic             do_pop;

  // A push into a completely full buffer is dropped; a pop needs data
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Storage array; contents only matter where the count says they are valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && (count == CW'(DEPTH))) overflow <= 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // The core must never deliver a result into a completely full buffer
  assert property (@(posedge clk) disable iff (rst) !overflow);

endmodule

// File: rtl/sw_query_stream_rx.sv
// Host stream channel endpoint: parses {header, query} word pairs into one
// aligner job each, and returns per-query results as 128-bit stream words.
module sw_query_stream_rx
  import sw_stream_pkg::*;
#(
  parameter int W          = 128,
  parameter int QUERY_BITS = 128,
  parameter int RES_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  si_valid,
  output logic                  si_rdy,
  input  logic [W-1:0]          si_data,
  output logic                  so_valid,
  input  logic                  so_rdy,
  output logic [W-1:0]          so_data,
  output logic                  job_valid,
  input  logic                  job_rdy,
  output logic [QUERY_BITS-1:0] job_query,
  output logic [6:0]            job_qlen,
  output logic [31:0]           job_ref_words,
  output logic [31:0]           job_threshold,
  output logic [15:0]           job_id,
  input  logic                  res_valid,
  input  logic [15:0]           res_id,
  input  logic [31:0]           res_loc,
  output logic                  res_full
);

  localparam int CW = $clog2(RES_DEPTH) + 1;

  rx_state_t              state_q;
  rx_state_t              state_d;
  logic                   hdr_load;
  logic                   qry_load;
  logic [CW-1:0]          res_count;
  logic [RES_ENTRY_W-1:0] fifo_dout;

  // Parser state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= HDR;
    else     state_q <= state_d;
  end

  // Next state and handshakes; nothing is accepted or offered while in reset
  always_comb begin
    state_d   = state_q;
    si_rdy    = 1'b0;
    job_valid = 1'b0;
    hdr_load  = 1'b0;
    qry_load  = 1'b0;
    if (!rst) begin
      case (state_q)
        HDR: begin
          si_rdy = 1'b1;
          if (si_valid) begin
            hdr_load = 1'b1;
            state_d  = QRY;
          end
        end
        QRY: begin
          si_rdy = 1'b1;
          if (si_valid) begin
            qry_load = 1'b1;
            state_d  = ISSUE;
          end
        end
        ISSUE: begin
          job_valid = !res_full;
          if (!res_full && job_rdy) state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end
  end

  // Job fields are captured from the stream and held stable until replaced
  always_ff @(posedge clk) begin
    if (rst) begin
      job_ref_words <= '0;
      job_id        <= '0;
      job_qlen      <= '0;
      job_threshold <= '0;
      job_query     <= '0;
    end else begin
      if (hdr_load) begin
        job_ref_words <= si_data[HDR_REF_LSB  +: HDR_REF_W];
        job_id        <= si_data[HDR_ID_LSB   +: HDR_ID_W];
        job_qlen      <= si_data[HDR_QLEN_LSB +: HDR_QLEN_W];
        job_threshold <= si_data[HDR_THR_LSB  +: HDR_THR_W];
      end
      if (qry_load) job_query <= si_data[QUERY_BITS-1:0];
    end
  end

  sw_result_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (RES_ENTRY_W),
    .CW    (CW)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_valid),
    .push_data ({res_id, res_loc}),
    .pop       (so_rdy),
    .out_valid (so_valid),
    .out_data  (fifo_dout),
    .count     (res_count)
  );

  assign so_data  = {{(W - RES_ENTRY_W){1'b0}}, fifo_dout};
  assign res_full = (res_count >= CW'(RES_DEPTH - 1));

endmodule

// File: tb/tb_sw_query_stream_rx.sv
// Directed bench for the stream endpoint: a vector table for the basic job and
// result flow, then hand-written sequences for stall, wrap, reset and streaming.
module tb_sw_query_stream_rx;

  localparam logic [127:0] H1 = 128'h0000007E_0000003F_00000000_00000008;
  localparam logic [127:0] Q1 = 128'hc8facaa7c280aa28a020aaaf89aae004;
  localparam logic [127:0] H2 = 128'h00000020_0000000A_00000005_00000100;
  localparam logic [127:0] Q2 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] H3 = 128'h00000009_00000009_00000009_00000009;
  localparam logic [127:0] H4 = 128'h00000003_00000014_00000007_00000055;
  localparam logic [127:0] Q4 = 128'h55555555_aaaaaaaa_33333333_cccccccc;

  logic         clk;
  logic         rst;
  logic         si_valid;
  logic         si_rdy;
  logic [127:0] si_data;
  logic         so_valid;
  logic         so_rdy;
  logic [127:0] so_data;
  logic         job_valid;
  logic         job_rdy;
  logic [127:0] job_query;
  logic [6:0]   job_qlen;
  logic [31:0]  job_ref_words;
  logic [31:0]  job_threshold;
  logic [15:0]  job_id;
  logic         res_valid;
  logic [15:0]  res_id;
  logic [31:0]  res_loc;
  logic         res_full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         si_valid;
    logic [127:0] si_data;
    logic         job_rdy;
    logic         res_valid;
    logic [15:0]  res_id;
    logic [31:0]  res_loc;
    logic         so_rdy;
    logic         exp_si_rdy;
    logic         exp_job_valid;
    logic [127:0] exp_query;
    logic [31:0]  exp_ref;
    logic [15:0]  exp_id;
    logic [6:0]   exp_qlen;
    logic [31:0]  exp_thr;
    logic         exp_so_valid;
    logic [47:0]  exp_so_data;
    logic         exp_res_full;
  } vec_t;

  vec_t vecs[6];

  sw_query_stream_rx #(
    .W          (128),
    .QUERY_BITS (128),
    .RES_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .si_valid      (si_valid),
    .si_rdy        (si_rdy),
    .si_data       (si_data),
    .so_valid      (so_valid),
    .so_rdy        (so_rdy),
    .so_data       (so_data),
    .job_valid     (job_valid),
    .job_rdy       (job_rdy),
    .job_query     (job_query),
    .job_qlen      (job_qlen),
    .job_ref_words (job_ref_words),
    .job_threshold (job_threshold),
    .job_id        (job_id),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_loc       (res_loc),
    .res_full      (res_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    si_valid  = v.si_valid;
    si_data   = v.si_data;
    job_rdy   = v.job_rdy;
    res_valid = v.res_valid;
    res_id    = v.res_id;
    res_loc   = v.res_loc;
    so_rdy    = v.so_rdy;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkJob(input string tag, input logic [31:0] ref_w, input logic [15:0] id,
                          input logic [6:0] qlen, input logic [31:0] thr);
    checkOutput({tag, " job_ref_words"}, 128'(job_ref_words), 128'(ref_w));
    checkOutput({tag, " job_id"},        128'(job_id),        128'(id));
    checkOutput({tag, " job_qlen"},      128'(job_qlen),      128'(qlen));
    checkOutput({tag, " job_threshold"}, 128'(job_threshold), 128'(thr));
  endtask

  initial begin
    logic [127:0] words [8];
    int idx;
    int issued;
    int last_issue;
    logic accepted;

    // Basic job issue followed by one result round trip
    vecs[0] = '{1'b1, H1, 1'b1, 1'b0, 16'h0, 32'h0, 1'b1,
                1'b1, 1'b0, 128'h0, 32'd0, 16'd0, 7'd0, 32'd0, 1'b0, 48'h0, 1'b0};
    vecs[1] = '{1'b1, Q1, 1'b1, 1'b0, 16'h0, 32'h0, 1'b1,
                1'b1, 1'b0, 128'h0, 32'd8, 16'd0, 7'd63, 32'd126, 1'b0, 48'h0, 1'b0};
    vecs[2] = '{1'b0, 128'h0, 1'b1, 1'b0, 16'h0, 32'h0, 1'b1,
                1'b0, 1'b1, Q1, 32'd8, 16'd0, 7'd63, 32'd126, 1'b0, 48'h0, 1'b0};
    vecs[3] = '{1'b0, 128'h0, 1'b0, 1'b1, 16'h0, 32'h40, 1'b1,
                1'b1, 1'b0, Q1, 32'd8, 16'd0, 7'd63, 32'd126, 1'b0, 48'h0, 1'b0};
    vecs[4] = '{1'b0, 128'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1,
                1'b1, 1'b0, Q1, 32'd8, 16'd0, 7'd63, 32'd126, 1'b1, 48'h0000_0000_0040, 1'b0};
    vecs[5] = '{1'b0, 128'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1,
                1'b1, 1'b0, Q1, 32'd8, 16'd0, 7'd63, 32'd126, 1'b0, 48'h0, 1'b0};

    rst = 1'b1; si_valid = 1'b0; si_data = '0; so_rdy = 1'b0;
    job_rdy = 1'b0; res_valid = 1'b0; res_id = '0; res_loc = '0;
    step(); step();
    checkOutput("reset si_rdy",    128'(si_rdy),    128'(0));
    checkOutput("reset job_valid", 128'(job_valid), 128'(0));
    checkOutput("reset so_valid",  128'(so_valid),  128'(0));
    checkOutput("reset res_full",  128'(res_full),  128'(0));
    checkOutput("reset so_data",   so_data,         128'h0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset si_rdy", 128'(si_rdy), 128'(1));

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d si_rdy", i),    128'(si_rdy),    128'(vecs[i].exp_si_rdy));
      checkOutput($sformatf("vec%0d job_valid", i), 128'(job_valid), 128'(vecs[i].exp_job_valid));
      checkOutput($sformatf("vec%0d job_query", i), job_query,       vecs[i].exp_query);
      checkJob($sformatf("vec%0d", i), vecs[i].exp_ref, vecs[i].exp_id, vecs[i].exp_qlen, vecs[i].exp_thr);
      checkOutput($sformatf("vec%0d so_valid", i),  128'(so_valid),  128'(vecs[i].exp_so_valid));
      checkOutput($sformatf("vec%0d so_data", i),   so_data,         128'(vecs[i].exp_so_data));
      checkOutput($sformatf("vec%0d res_full", i),  128'(res_full),  128'(vecs[i].exp_res_full));
      step();
    end

    // Core stalls for 5 cycles; the following header must wait
    so_rdy = 1'b0; res_valid = 1'b0;
    si_valid = 1'b1; si_data = H1; job_rdy = 1'b0; step();
    si_data = Q1; step();
    si_data = H2;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("stall%0d si_rdy", c),    128'(si_rdy),    128'(0));
      checkOutput($sformatf("stall%0d job_valid", c), 128'(job_valid), 128'(1));
      checkOutput($sformatf("stall%0d job_query", c), job_query,       Q1);
      checkJob($sformatf("stall%0d", c), 32'd8, 16'd0, 7'd63, 32'd126);
      step();
    end
    job_rdy = 1'b1;
    #1;
    checkOutput("stall release job_valid", 128'(job_valid), 128'(1));
    step();
    job_rdy = 1'b0;
    #1;
    checkOutput("after issue job_valid", 128'(job_valid), 128'(0));
    checkOutput("after issue si_rdy",    128'(si_rdy),    128'(1));
    step();
    si_data = Q2;
    #1;
    checkOutput("held header si_rdy", 128'(si_rdy), 128'(1));
    checkJob("held header", 32'h100, 16'd5, 7'd10, 32'h20);
    step();
    si_valid = 1'b0; job_rdy = 1'b1;
    #1;
    checkOutput("second job valid", 128'(job_valid), 128'(1));
    checkOutput("second job query", job_query,       Q2);
    step();
    job_rdy = 1'b0;

    // Fill the result buffer, block ISSUE, then drain across pointer wrap
    so_rdy = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      res_valid = 1'b1; res_id = 16'(k); res_loc = 32'(k * 'h11);
      step();
      res_valid = 1'b0;
      #1;
      checkOutput($sformatf("fill%0d res_full", k), 128'(res_full), 128'(k >= 3));
      checkOutput($sformatf("fill%0d so_valid", k), 128'(so_valid), 128'(1));
    end
    checkOutput("fill head so_data", so_data, 128'h0001_0000_0011);
    si_valid = 1'b1; si_data = H1; job_rdy = 1'b1; step();
    si_data = Q1; step();
    si_valid = 1'b0;
    #1;
    checkOutput("blocked job_valid", 128'(job_valid), 128'(0));
    checkOutput("blocked si_rdy",    128'(si_rdy),    128'(0));
    step();
    #1;
    checkOutput("still blocked job_valid", 128'(job_valid), 128'(0));
    so_rdy = 1'b1; res_valid = 1'b1; res_id = 16'd4; res_loc = 32'h44;
    #1;
    checkOutput("wrap out1", so_data, 128'h0001_0000_0011);
    step();
    res_valid = 1'b0;
    #1;
    checkOutput("wrap out2",       so_data,         128'h0002_0000_0022);
    checkOutput("wrap count3 full", 128'(res_full),  128'(1));
    checkOutput("wrap job blocked", 128'(job_valid), 128'(0));
    step();
    #1;
    checkOutput("wrap out3",        so_data,         128'h0003_0000_0033);
    checkOutput("wrap not full",    128'(res_full),  128'(0));
    checkOutput("wrap job unblock", 128'(job_valid), 128'(1));
    step();
    job_rdy = 1'b0;
    #1;
    checkOutput("wrap out4",      so_data,         128'h0004_0000_0044);
    checkOutput("wrap out4 valid", 128'(so_valid),  128'(1));
    checkOutput("wrap job done",  128'(job_valid), 128'(0));
    step();
    #1;
    checkOutput("wrap empty valid", 128'(so_valid), 128'(0));
    checkOutput("wrap empty data",  so_data,        128'h0);

    // Reset after a header only; the partial pair must be discarded
    si_valid = 1'b1; si_data = H3; step();
    rst = 1'b1; si_data = H4;
    #1;
    checkOutput("midreset si_rdy",    128'(si_rdy),    128'(0));
    checkOutput("midreset job_valid", 128'(job_valid), 128'(0));
    step();
    rst = 1'b0;
    #1;
    checkOutput("postreset si_rdy", 128'(si_rdy), 128'(1));
    checkOutput("postreset job_id", 128'(job_id), 128'(0));
    step();
    si_data = Q4;
    #1;
    checkOutput("new hdr job_valid", 128'(job_valid), 128'(0));
    checkJob("new hdr", 32'h55, 16'd7, 7'd20, 32'd3);
    step();
    si_valid = 1'b0; job_rdy = 1'b1;
    #1;
    checkOutput("new job valid", 128'(job_valid), 128'(1));
    checkOutput("new job query", job_query,       Q4);
    checkOutput("new job id",    128'(job_id),    128'(7));
    step();

    // Back-to-back pairs with an always-ready stream and core
    for (int k = 0; k < 4; k++) begin
      words[2*k]   = {32'd1, 32'hFFFF_FF85, 16'hABCD, 16'(k), 32'd1};
      words[2*k+1] = {96'h0, 32'(k)};
    end
    idx = 0; issued = 0; last_issue = 0;
    job_rdy = 1'b1;
    for (int c = 0; c < 40 && issued < 4; c++) begin
      si_valid = (idx < 8);
      si_data  = words[(idx < 8) ? idx : 0];
      #1;
      if (job_valid && job_rdy) begin
        checkOutput($sformatf("b2b job%0d id", issued),   128'(job_id),   128'(issued));
        checkOutput($sformatf("b2b job%0d qlen", issued), 128'(job_qlen), 128'(5));
        if (issued > 0)
          checkOutput($sformatf("b2b job%0d spacing", issued), 128'(c - last_issue), 128'(3));
        last_issue = c;
        issued++;
      end
      accepted = si_valid && si_rdy;
      step();
      if (accepted) idx++;
    end
    checkOutput("b2b jobs issued", 128'(issued), 128'(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
